adder_arbiter: RTL

- Round-robin arbiter and sequencer that shares one W-bit ripple-carry adder, built from FullAdder cells, between NREQ requesters.
- Each requester presents operands and a carry-in and holds a request.
- The block grants one requester at a time, captures its operands, registers the sum and carry-out, then pulses a per-requester done.
- Sits between the HW2 datapath clients and the single shared adder instance.

---
 rtl/adder_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter/sequencer sharing one W-bit
// ripple-carry adder (built from full_adder cells) among NREQ requesters.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   req    - per-requester request, held with operands until done/abort
//   a, b   - packed operands, requester i on [i*W +: W]
//   ci     - per-requester carry-in
//   sub    - per-requester subtract select (only with ADDER_ARBITER_SUB_EN)
//   gnt    - one-hot grant, zero when idle
//   s, co  - registered sum / carry-out of the last completed operation
//   done   - one-cycle completion pulse to the served requester
//   busy   - high whenever the FSM is not IDLE
//
// Optional feature macro: ADDER_ARBITER_SUB_EN (adds the sub port; a - b
// computed as a + ~b + 1, co=1 meaning no borrow).

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_arbiter #(
  parameter int W    = 10,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a,
  input  logic [NREQ*W-1:0] b,
  input  logic [NREQ-1:0]   ci,
`ifdef ADDER_ARBITER_SUB_EN
  input  logic [NREQ-1:0]   sub,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      s,
  output logic              co,
  output logic [NREQ-1:0]   done,
  output logic              busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [IW-1:0]   last_q, last_d;
  logic [W-1:0]    opa_q, opb_q;
  logic            opc_q;
  logic [W-1:0]    s_q;
  logic            co_q;
  logic            load_en, res_en;

  // unpacked views of the per-requester operand buses
  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = a[i*W +: W];
    assign b_arr[i] = b[i*W +: W];
  end

  // round-robin pick: first set req searching upward from last+1, wrapping
  logic          win_found;
  logic [IW-1:0] win_idx;
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // next-state / control
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    load_en = 1'b0;
    res_en  = 1'b0;
    unique case (state_q)
      IDLE: if (win_found) begin
        k_d     = win_idx;
        state_d = LOAD;
      end
      LOAD: begin
        // a requester that dropped req before capture aborts the slot
        // without moving the priority pointer
        if (req[k_q]) begin
          load_en = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        res_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        last_d  = k_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // operand capture; subtraction folds into the stored operands so the
  // adder itself stays a plain a + b + cin
  logic [W-1:0] cap_b;
  logic         cap_c;
  always_comb begin
    cap_b = b_arr[k_q];
    cap_c = ci[k_q];
`ifdef ADDER_ARBITER_SUB_EN
    if (sub[k_q]) begin
      cap_b = ~b_arr[k_q];
      cap_c = 1'b1;
    end
`endif
  end

  // shared ripple-carry adder
  logic [W:0]   carry;
  logic [W-1:0] sum;
  assign carry[0] = opc_q;
  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a  (opa_q[i]),
      .b  (opb_q[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      last_q  <= IW'(NREQ-1);
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      last_q  <= last_d;
      if (load_en) begin
        opa_q <= a_arr[k_q];
        opb_q <= cap_b;
        opc_q <= cap_c;
      end
      if (res_en) begin
        s_q  <= sum;
        co_q <= carry[W];
      end
    end
  end

  logic [NREQ-1:0] sel_oh;
  assign sel_oh = NREQ'(1) << k_q;
  assign busy   = (state_q != IDLE);
  assign gnt    = busy ? sel_oh : '0;
  assign done   = (state_q == DONE) ? sel_oh : '0;
  assign s      = s_q;
  assign co     = co_q;

endmodule
